// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// buffers fetched {pc, instr} pairs in a small prefetch queue for decode.
//
// Handshake (out_*): an entry transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_pc and out_instr hold steady. out_valid does not depend on out_ready.
// A redirect discards the queue; a transfer in the redirect cycle still counts.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   q_pc    [FIFO_DEPTH];
  logic [31:0]   q_instr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Low address bits of the redirect target are ignored by construction.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ROM sees the PC register directly, so the word is fetched every cycle.
  assign imem_addr = pc;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full queue can still accept when its head leaves in the same cycle.
  assign push      = !redirect_valid && ((count < DEPTH_C) || pop);

  // Head data is masked to zero when nothing valid is presented.
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; only written on an accepted fetch.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an expected-transfer queue and monitor.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // Clock
  always #5 clk = ~clk;

  // ROM model: word i holds 0x100 + i
  assign imem_instr = 32'h100 + {2'b00, imem_addr[31:2]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, 32'h100 + (pc >> 2)});
  endtask

  // Monitor: every completed transfer must match the next expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected: got pc=%h instr=%h expected none", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL monitor_xfer: got pc=%h instr=%h expected pc=%h instr=%h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_instr", out_instr, 32'h0);
    check("reset_addr", imem_addr, 32'h0);

    // Streaming with ready held high
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    @(negedge clk);
    check("t1_first_cycle_valid", {31'b0, out_valid}, 32'h0);
    check("t1_first_cycle_addr", imem_addr, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_valid", {31'b0, out_valid}, 32'h1);
      check("t1_pc", out_pc, 32'(i * 4));
      tick();
    end
    out_ready = 1'b0;

    // Back-pressure: queue fills, pc freezes, head holds
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t2_fetch_cycle_valid", {31'b0, out_valid}, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'b0, out_valid}, 32'h1);
      check("t2_hold_pc", out_pc, 32'h0);
      check("t2_hold_instr", out_instr, 32'h100);
      if (k >= 1) check("t2_pc_frozen", imem_addr, 32'h8);
      tick();
    end
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_drain_valid", {31'b0, out_valid}, 32'h1);
      check("t2_drain_pc", out_pc, 32'(i * 4));
      tick();
    end
    out_ready = 1'b0;

    // Redirect with a full queue, unaligned target
    @(negedge clk);
    check("t3_full_head", out_pc, 32'hC);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_flush_valid", {31'b0, out_valid}, 32'h0);
    check("t3_flush_pc_masked", out_pc, 32'h0);
    check("t3_target_addr", imem_addr, 32'h40);
    tick();
    @(negedge clk);
    check("t3_target_valid", {31'b0, out_valid}, 32'h1);
    check("t3_target_pc", out_pc, 32'h40);
    check("t3_target_instr", out_instr, 32'h110);
    tick();

    // Redirect in the same cycle as a pop
    push_exp(32'h40);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("t4_pop_pc", out_pc, 32'h40);
    tick();
    redirect_valid = 1'b0;
    push_exp(32'h200);
    push_exp(32'h204);
    push_exp(32'h208);
    @(negedge clk);
    check("t4_flush_valid", {31'b0, out_valid}, 32'h0);
    check("t4_target_addr", imem_addr, 32'h200);
    tick();
    @(negedge clk);
    check("t4_target_pc", out_pc, 32'h200);
    tick();
    @(negedge clk);
    check("t4_next_pc", out_pc, 32'h204);
    tick();

    // Redirect to the top word, PC wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    check("t5_pop_pc", out_pc, 32'h208);
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, 32'h4000_00FF});
    exp_q.push_back({32'h0000_0000, 32'h0000_0100});
    @(negedge clk);
    check("t5_flush_valid", {31'b0, out_valid}, 32'h0);
    check("t5_target_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("t5_top_pc", out_pc, 32'hFFFF_FFFC);
    check("t5_top_instr", out_instr, 32'h4000_00FF);
    tick();
    @(negedge clk);
    check("t5_wrap_pc", out_pc, 32'h0);
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("t5_full_head", out_pc, 32'h4);
    check("t5_full_addr", imem_addr, 32'hC);

    // Reset overrides a simultaneous redirect
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    @(negedge clk);
    check("t6_reset_valid", {31'b0, out_valid}, 32'h0);
    check("t6_reset_pc_masked", out_pc, 32'h0);
    check("t6_reset_addr", imem_addr, 32'h0);
    tick();
    @(negedge clk);
    check("t6_first_pc", out_pc, 32'h0);
    tick();
    @(negedge clk);
    check("t6_second_pc", out_pc, 32'h4);
    tick();
    out_ready = 1'b0;
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drained: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
